monitor_alarme_sala: RTL

Sequential, parametrised alarm monitor for the control room. It watches N_CANAIS sensor channels (temperature, pressure, radiation, or any others) against runtime thresholds. Each channel has a selectable direction and signedness, a persistence filter, a latched alarm, operator acknowledge and hysteresis on clear. It drives the audible and visual annunciators and a first-out indication for the operator panel.

---
 rtl/monitor_alarme_sala_pkg.sv | 14 +
 rtl/monitor_alarme_sala_canal.sv | 109 ++++++++++
 rtl/monitor_alarme_sala.sv | 97 +++++++++
 3 files changed

// File: rtl/monitor_alarme_sala_pkg.sv
// Shared types and constants for the control-room alarm monitor.
package monitor_alarme_sala_pkg;

  typedef enum logic [1:0] {
    NORMAL      = 2'd0,
    SUSPEITO    = 2'd1,
    ALARME      = 2'd2,
    RECONHECIDO = 2'd3
  } estado_t;

  localparam logic MODO_ACIMA  = 1'b0;
  localparam logic MODO_ABAIXO = 1'b1;

endpackage

// File: rtl/monitor_alarme_sala_canal.sv
// One monitored channel: threshold compare, hysteresis clear, persistence
// counter and latched alarm/acknowledge FSM.
module canal_alarme_fsm
  import monitor_alarme_sala_pkg::*;
#(
  parameter int W       = 12,
  parameter int PERSIST = 3,
  parameter int HIST    = 10,
  parameter int CW      = $clog2(PERSIST + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         amostra_valida,
  input  logic [W-1:0] medida,
  input  logic [W-1:0] limiar,
  input  logic         modo_abaixo,
  input  logic         com_sinal,
  input  logic         reconhecer,
  output logic         dispara,
  output logic         ativo_d,
  output logic         alarme_d
);

  localparam int XW = W + 2;
  localparam logic signed [XW-1:0] S_MIN  = {{3{1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [XW-1:0] S_MAX  = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [XW-1:0] U_MIN  = '0;
  localparam logic signed [XW-1:0] U_MAX  = {2'b00, {W{1'b1}}};
  localparam logic signed [XW-1:0] HIST_X = XW'(HIST);
  localparam logic [CW-1:0]        PERSIST_C = CW'(PERSIST);

  estado_t             estado_q, estado_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic signed [XW-1:0] med_x, lim_x, margem, faixa_min, faixa_max;
  logic                abaixo, viola, fora_faixa, limpa;

  // Two guard bits instead of one so limiar+HIST never wraps for unsigned
  // inputs; an out-of-range margin simply disables clearing (saturated).
  always_comb begin
    abaixo     = (modo_abaixo == MODO_ABAIXO);
    med_x      = com_sinal ? {{2{medida[W-1]}}, medida} : {2'b00, medida};
    lim_x      = com_sinal ? {{2{limiar[W-1]}}, limiar} : {2'b00, limiar};
    faixa_min  = com_sinal ? S_MIN : U_MIN;
    faixa_max  = com_sinal ? S_MAX : U_MAX;
    margem     = abaixo ? (lim_x + HIST_X) : (lim_x - HIST_X);
    fora_faixa = abaixo ? (margem > faixa_max) : (margem < faixa_min);
    viola      = abaixo ? (med_x <= lim_x) : (med_x >= lim_x);
    limpa      = !fora_faixa && (abaixo ? (med_x > margem) : (med_x < margem));
  end

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    case (estado_q)
      NORMAL: begin
        if (amostra_valida && viola) begin
          if (PERSIST == 1) begin
            estado_d = ALARME;
          end else begin
            estado_d = SUSPEITO;
            cnt_d    = CW'(1);
          end
        end
      end
      SUSPEITO: begin
        if (amostra_valida) begin
          if (viola) begin
            if (cnt_q + CW'(1) == PERSIST_C) begin
              estado_d = ALARME;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            estado_d = NORMAL;
            cnt_d    = '0;
          end
        end
      end
      ALARME: begin
        if (reconhecer) estado_d = RECONHECIDO;
      end
      RECONHECIDO: begin
        if (amostra_valida && limpa) estado_d = NORMAL;
      end
      default: begin
        estado_d = NORMAL;
        cnt_d    = '0;
      end
    endcase
  end

  always_comb begin
    alarme_d = (estado_d == ALARME);
    ativo_d  = (estado_d == ALARME) || (estado_d == RECONHECIDO);
    dispara  = (estado_d == ALARME) && (estado_q != ALARME);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q <= NORMAL;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/monitor_alarme_sala.sv
// Control-room alarm monitor top: per-channel FSMs, annunciator OR trees and
// first-out latch. All outputs come straight from flops.
module monitor_alarme_sala
  import monitor_alarme_sala_pkg::*;
#(
  parameter int N_CANAIS = 3,
  parameter int W        = 12,
  parameter int PERSIST  = 3,
  parameter int HIST     = 10,
  parameter int CW       = $clog2(PERSIST + 1),
  parameter int IW       = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  amostra_valida,
  input  logic [N_CANAIS*W-1:0] medidas,
  input  logic [N_CANAIS*W-1:0] limiares,
  input  logic [N_CANAIS-1:0]   modo_abaixo,
  input  logic [N_CANAIS-1:0]   com_sinal,
  input  logic [N_CANAIS-1:0]   reconhecer,
  output logic [N_CANAIS-1:0]   canais_alarme,
  output logic                  alarme_sonoro,
  output logic                  alarme_visual,
  output logic [IW-1:0]         primeiro_canal,
  output logic                  primeiro_valido
);

  logic [N_CANAIS-1:0] dispara, ativo_d, alarme_d;

  for (genvar g = 0; g < N_CANAIS; g++) begin : g_canal
    canal_alarme_fsm #(
      .W       (W),
      .PERSIST (PERSIST),
      .HIST    (HIST),
      .CW      (CW)
    ) u_canal (
      .clk            (clk),
      .rst_n          (rst_n),
      .amostra_valida (amostra_valida),
      .medida         (medidas[g*W +: W]),
      .limiar         (limiares[g*W +: W]),
      .modo_abaixo    (modo_abaixo[g]),
      .com_sinal      (com_sinal[g]),
      .reconhecer     (reconhecer[g]),
      .dispara        (dispara[g]),
      .ativo_d        (ativo_d[g]),
      .alarme_d       (alarme_d[g])
    );
  end

  logic [N_CANAIS-1:0] canais_q, canais_d;
  logic                sonoro_q, sonoro_d, visual_q, visual_d;
  logic [IW-1:0]       pc_q, pc_d;
  logic                pv_q, pv_d;

  // Outputs are registered from the channels' next state so an alarm is
  // visible right after the edge that trips it.
  always_comb begin
    canais_d = ativo_d;
    sonoro_d = |alarme_d;
    visual_d = |ativo_d;
    pc_d     = pc_q;
    pv_d     = pv_q;
    if (!(|ativo_d)) begin
      pv_d = 1'b0;
      pc_d = '0;
    end else if (!pv_q && (|dispara)) begin
      pv_d = 1'b1;
      for (int unsigned i = N_CANAIS; i > 0; i--) begin
        if (dispara[i-1]) pc_d = IW'(i - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      canais_q <= '0;
      sonoro_q <= 1'b0;
      visual_q <= 1'b0;
      pc_q     <= '0;
      pv_q     <= 1'b0;
    end else begin
      canais_q <= canais_d;
      sonoro_q <= sonoro_d;
      visual_q <= visual_d;
      pc_q     <= pc_d;
      pv_q     <= pv_d;
    end
  end

  assign canais_alarme   = canais_q;
  assign alarme_sonoro   = sonoro_q;
  assign alarme_visual   = visual_q;
  assign primeiro_canal  = pc_q;
  assign primeiro_valido = pv_q;

endmodule
